// File: rtl/vram_arb.sv
// vram_arb: single-port VRAM arbiter between a graphics line fetcher and the CPU.
// The graphics fetcher owns the RAM whenever gfx_start or gfx_busy is high; the
// CPU gets the leftover cycles through a small IDLE / RD_WAIT / ACK state machine.
// Optional macro VRAM_ARB_WRBUF_EN compiles in a 2-entry posted-write FIFO.
//
// Handshake: cpu_req is held high with stable fields until cpu_ack; cpu_ack is a
// single-cycle registered pulse, and a new request is only looked at from the
// cycle after cpu_ack (the ACK state blocks issue), so acks are never back to back.
module vram_arb #(
    parameter int STALL_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               gfx_start,
    input  logic               gfx_busy,
    input  logic [13:0]        gfx_vaddr,
    output logic [15:0]        gfx_vdata,
    input  logic               cpu_req,
    input  logic               cpu_wren,
    input  logic [13:0]        cpu_addr,
    input  logic [15:0]        cpu_wrdata,
    input  logic [1:0]         cpu_bytesel,
    output logic               cpu_ack,
    output logic [15:0]        cpu_rddata,
    output logic [13:0]        ram_addr,
    output logic [15:0]        ram_wrdata,
    output logic [1:0]         ram_wren,
    input  logic [15:0]        ram_rddata,
    output logic [STALL_W-1:0] stall_max,
    output logic [1:0]         o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD_WAIT = 2'd1,
        S_ACK     = 2'd2
    } state_t;

    state_t               r_state;
    logic                 r_ack;
    logic [15:0]          r_rddata;
    logic [STALL_W-1:0]   r_stall_cnt;
    logic [STALL_W-1:0]   r_stall_max;

    logic w_gfx_own;
    logic w_idle;
    logic w_rd_issue;
    logic w_wr_go;
    logic w_accept;
    logic w_waiting;

    assign w_gfx_own = gfx_start | gfx_busy;
    // Reset forces the RAM port back to the graphics address with no write.
    assign w_idle    = (r_state == S_IDLE) && !reset;
    assign gfx_vdata = ram_rddata;

`ifdef VRAM_ARB_WRBUF_EN
    logic [13:0] r_fifo_addr [2];
    logic [15:0] r_fifo_data [2];
    logic [1:0]  r_fifo_bsel [2];
    logic        r_rd_ptr;
    logic        r_wr_ptr;
    logic [1:0]  r_count;
    logic        w_empty;
    logic        w_full;
    logic        w_pop;

    assign w_empty    = (r_count == 2'd0);
    assign w_full     = (r_count == 2'd2);
    // Buffered writes drain whenever graphics leaves the port free, oldest first.
    assign w_pop      = !w_empty && !w_gfx_own && !reset;
    // Writes are posted into the FIFO even while graphics owns the RAM.
    assign w_wr_go    = w_idle && cpu_req && cpu_wren && !w_full;
    // Reads wait for the FIFO to empty so they never overtake a posted write.
    assign w_rd_issue = w_idle && cpu_req && !cpu_wren && !w_gfx_own && w_empty;
    assign ram_addr   = w_pop ? r_fifo_addr[r_rd_ptr] : (w_rd_issue ? cpu_addr : gfx_vaddr);
    assign ram_wren   = w_pop ? r_fifo_bsel[r_rd_ptr] : 2'b00;
    assign ram_wrdata = r_fifo_data[r_rd_ptr];

    // Posted-write FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                r_fifo_addr[i] <= '0;
                r_fifo_data[i] <= '0;
                r_fifo_bsel[i] <= '0;
            end
        end else begin
            if (w_wr_go) begin
                r_fifo_addr[r_wr_ptr] <= cpu_addr;
                r_fifo_data[r_wr_ptr] <= cpu_wrdata;
                r_fifo_bsel[r_wr_ptr] <= cpu_bytesel;
                r_wr_ptr              <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            if (w_wr_go && !w_pop) begin
                r_count <= r_count + 2'd1;
            end else if (!w_wr_go && w_pop) begin
                r_count <= r_count - 2'd1;
            end
        end
    end
`else
    assign w_wr_go    = w_idle && cpu_req && cpu_wren && !w_gfx_own;
    assign w_rd_issue = w_idle && cpu_req && !cpu_wren && !w_gfx_own;
    assign ram_addr   = (w_rd_issue || w_wr_go) ? cpu_addr : gfx_vaddr;
    assign ram_wren   = w_wr_go ? cpu_bytesel : 2'b00;
    assign ram_wrdata = cpu_wrdata;
`endif

    assign w_accept = w_rd_issue || w_wr_go;
    // Only cycles spent waiting in IDLE count as stall; an access already in
    // flight (RD_WAIT, ACK) is normal latency, not a stall.
    assign w_waiting = cpu_req && (r_state == S_IDLE) && !w_accept;

    // CPU access state machine with registered ack and read data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_ack    <= 1'b0;
            r_rddata <= 16'h0000;
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_rd_issue) begin
                        r_state <= S_RD_WAIT;
                    end else if (w_wr_go) begin
                        r_state <= S_ACK;
                        r_ack   <= 1'b1;
                    end
                end
                S_RD_WAIT: begin
                    r_rddata <= ram_rddata;
                    r_state  <= S_ACK;
                    r_ack    <= 1'b1;
                end
                S_ACK: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Stall counter and high-water mark, both saturating.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_stall_max <= '0;
        end else begin
            if (w_accept) begin
                r_stall_cnt <= '0;
            end else if (w_waiting && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + STALL_W'(1);
            end
            if (r_stall_cnt > r_stall_max) begin
                r_stall_max <= r_stall_cnt;
            end
        end
    end

    assign cpu_ack     = r_ack;
    assign cpu_rddata  = r_rddata;
    assign stall_max   = r_stall_max;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_vram_arb.sv
// tb_vram_arb: randomized scoreboard bench for vram_arb with a behavioural VRAM
// and a word-level reference memory. Covers the posted-write FIFO when
// VRAM_ARB_WRBUF_EN is defined.
module tb_vram_arb;

    localparam int STALL_W = 8;

    logic               clk = 1'b0;
    logic               reset;
    logic               gfx_start;
    logic               gfx_busy;
    logic [13:0]        gfx_vaddr;
    logic [15:0]        gfx_vdata;
    logic               cpu_req;
    logic               cpu_wren;
    logic [13:0]        cpu_addr;
    logic [15:0]        cpu_wrdata;
    logic [1:0]         cpu_bytesel;
    logic               cpu_ack;
    logic [15:0]        cpu_rddata;
    logic [13:0]        ram_addr;
    logic [15:0]        ram_wrdata;
    logic [1:0]         ram_wren;
    logic [15:0]        ram_rddata;
    logic [STALL_W-1:0] stall_max;
    logic [1:0]         dbg_state;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] exp_q[$];
    logic [15:0] ref_mem [int];
    logic [15:0] last_rd;
    int          exp_stall;
    logic        prev_ack = 1'b0;

    vram_arb #(.STALL_W(STALL_W)) dut (
        .clk(clk), .reset(reset),
        .gfx_start(gfx_start), .gfx_busy(gfx_busy), .gfx_vaddr(gfx_vaddr), .gfx_vdata(gfx_vdata),
        .cpu_req(cpu_req), .cpu_wren(cpu_wren), .cpu_addr(cpu_addr), .cpu_wrdata(cpu_wrdata),
        .cpu_bytesel(cpu_bytesel), .cpu_ack(cpu_ack), .cpu_rddata(cpu_rddata),
        .ram_addr(ram_addr), .ram_wrdata(ram_wrdata), .ram_wren(ram_wren), .ram_rddata(ram_rddata),
        .stall_max(stall_max), .o_dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

    // ---------------- environment: VRAM with 1-cycle read latency ----------------
    function automatic logic [15:0] init_val(input logic [13:0] a);
        if (a == 14'h0123) return 16'hBEEF;
        if (a == 14'h3FFF) return 16'h1234;
        return {2'b10, a} ^ 16'h5A3C;
    endfunction

    logic [15:0] mem [0:16383];
    bit          mem_vld [0:16383];
    logic [15:0] ram_old;

    always @(posedge clk) begin
        ram_old    = mem_vld[ram_addr] ? mem[ram_addr] : init_val(ram_addr);
        ram_rddata <= ram_old;
        if (ram_wren != 2'b00) begin
            mem[ram_addr]     <= {ram_wren[1] ? ram_wrdata[15:8] : ram_old[15:8],
                                  ram_wren[0] ? ram_wrdata[7:0]  : ram_old[7:0]};
            mem_vld[ram_addr] <= 1'b1;
        end
    end

    // Graphics address wanders every cycle, as a real fetcher's would.
    initial begin
        gfx_vaddr = 14'h0;
        forever begin
            @(negedge clk);
            gfx_vaddr = 14'($urandom);
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [15:0] ref_rd(input logic [13:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return init_val(a);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- driver tasks ----------------
    // One CPU access; lat = rising edges from request until cpu_ack is seen.
    task automatic cpu_access(input bit wr, input logic [13:0] addr, input logic [15:0] data,
                              input logic [1:0] bs, input bit chk_t, output int lat);
        logic [15:0] old;
        int          stall;
        @(negedge clk);
        cpu_req     = 1'b1;
        cpu_wren    = wr;
        cpu_addr    = addr;
        cpu_wrdata  = data;
        cpu_bytesel = bs;
        if (wr) begin
            old = ref_rd(addr);
            ref_mem[int'(addr)] = {bs[1] ? data[15:8] : old[15:8], bs[0] ? data[7:0] : old[7:0]};
            exp_q.push_back(last_rd);
        end else begin
            last_rd = ref_rd(addr);
            exp_q.push_back(last_rd);
        end
        if (chk_t) begin
            #1;
            check("issue_addr", 32'(ram_addr), 32'(addr));
            check("issue_wren", 32'(ram_wren), 32'(wr ? bs : 2'b00));
        end
        lat = 0;
        while (lat < 400) begin
            @(negedge clk);
            lat++;
            if (cpu_ack) break;
        end
        check("ack_timeout", 32'(cpu_ack), 32'd1);
        cpu_req = 1'b0;
        stall = lat - (wr ? 1 : 2);
        if (stall > 255) stall = 255;
        if (stall > exp_stall) exp_stall = stall;
    endtask

    task automatic gfx_line(input int busy_cycles);
        @(negedge clk);
        gfx_start = 1'b1;
        @(negedge clk);
        gfx_start = 1'b0;
        gfx_busy  = 1'b1;
        repeat (busy_cycles - 1) @(negedge clk);
        gfx_busy = 1'b0;
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [15:0] exp;
        #1;
        check("gfx_vdata", 32'(gfx_vdata), 32'(ram_rddata));
        if (gfx_start || gfx_busy || reset) begin
            check("gfx_own_addr", 32'(ram_addr), 32'(gfx_vaddr));
            check("gfx_own_wren", 32'(ram_wren), 32'd0);
        end
        if (cpu_ack) begin
            check("ack_gap", 32'(prev_ack), 32'd0);
            check("ack_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                check("cpu_rddata", 32'(cpu_rddata), 32'(exp));
            end
        end
        prev_ack = cpu_ack;
    end

    // ---------------- main sequence ----------------
    initial begin
        int lat;
        int lat3;
        reset = 1'b1;
        gfx_start = 1'b0; gfx_busy = 1'b0;
        cpu_req = 1'b0; cpu_wren = 1'b0; cpu_addr = '0; cpu_wrdata = '0; cpu_bytesel = '0;
        last_rd = 16'h0; exp_stall = 0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_ack", 32'(cpu_ack), 32'd0);
        check("rst_rddata", 32'(cpu_rddata), 32'd0);
        check("rst_stall_max", 32'(stall_max), 32'd0);
        check("rst_wren", 32'(ram_wren), 32'd0);
        check("rst_addr", 32'(ram_addr), 32'(gfx_vaddr));
        @(negedge clk);
        reset = 1'b0;

        // Plain read with graphics idle.
        cpu_access(1'b0, 14'h0123, 16'h0, 2'b00, 1'b1, lat);
        check("rd_latency", 32'(lat), 32'd2);
        check("rd_data_beef", 32'(cpu_rddata), 32'hBEEF);
        check("rd_stall_max", 32'(stall_max), 32'd0);

        // Read pending through a 50-cycle busy window.
        fork
            begin
                @(negedge clk);
                gfx_busy = 1'b1;
                repeat (50) @(negedge clk);
                gfx_busy = 1'b0;
            end
            cpu_access(1'b0, 14'h0200, 16'h0, 2'b00, 1'b0, lat);
        join
        check("busy_rd_latency", 32'(lat), 32'd52);
        check("busy_stall_max", 32'(stall_max), 32'd50);

        // gfx_start in the same cycle as the read request, then 5 busy cycles.
        fork
            begin
                @(negedge clk);
                gfx_start = 1'b1;
                @(negedge clk);
                gfx_start = 1'b0;
                gfx_busy  = 1'b1;
                repeat (5) @(negedge clk);
                gfx_busy = 1'b0;
            end
            cpu_access(1'b0, 14'h0300, 16'h0, 2'b00, 1'b0, lat);
        join
        check("start_rd_latency", 32'(lat), 32'd8);

        // Upper-byte write to the top address, then read back.
`ifdef VRAM_ARB_WRBUF_EN
        cpu_access(1'b1, 14'h3FFF, 16'hA55A, 2'b10, 1'b0, lat);
`else
        cpu_access(1'b1, 14'h3FFF, 16'hA55A, 2'b10, 1'b1, lat);
`endif
        check("wr_latency", 32'(lat), 32'd1);
        check("wr_holds_rddata", 32'(cpu_rddata), 32'(last_rd));
        cpu_access(1'b0, 14'h3FFF, 16'h0, 2'b00, 1'b0, lat);
        check("bytesel_readback", 32'(cpu_rddata), 32'hA534);

        // Write with no byte enables leaves memory untouched.
        cpu_access(1'b1, 14'h0123, 16'h0000, 2'b00, 1'b0, lat);
        check("wr_bs0_latency", 32'(lat), 32'd1);
        cpu_access(1'b0, 14'h0123, 16'h0, 2'b00, 1'b0, lat);
        check("bs0_readback", 32'(cpu_rddata), 32'hBEEF);

`ifdef VRAM_ARB_WRBUF_EN
        // Three posted writes while graphics is busy: the third must wait for a drain.
        fork
            begin
                @(negedge clk);
                gfx_busy = 1'b1;
                repeat (10) @(negedge clk);
                gfx_busy = 1'b0;
            end
            begin
                cpu_access(1'b1, 14'h0400, 16'h1111, 2'b11, 1'b0, lat);
                check("fifo_wr1_latency", 32'(lat), 32'd1);
                cpu_access(1'b1, 14'h0400, 16'h2222, 2'b11, 1'b0, lat);
                check("fifo_wr2_latency", 32'(lat), 32'd1);
                cpu_access(1'b1, 14'h0401, 16'h3333, 2'b11, 1'b0, lat3);
                check("fifo_wr3_waits", 32'(lat3 > 1), 32'd1);
            end
        join
        cpu_access(1'b0, 14'h0400, 16'h0, 2'b00, 1'b0, lat);
        check("fifo_order", 32'(cpu_rddata), 32'h2222);
        cpu_access(1'b0, 14'h0401, 16'h0, 2'b00, 1'b0, lat);
        check("fifo_wr3_data", 32'(cpu_rddata), 32'h3333);
`endif

        // Reset while a read sits in RD_WAIT: it must vanish without an ack.
        @(negedge clk);
        cpu_req = 1'b1; cpu_wren = 1'b0; cpu_addr = 14'h0200;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_mid_ack", 32'(cpu_ack), 32'd0);
        check("rst_mid_rddata", 32'(cpu_rddata), 32'd0);
        check("rst_mid_stall_max", 32'(stall_max), 32'd0);
        check("rst_mid_wren", 32'(ram_wren), 32'd0);
        check("rst_mid_addr", 32'(ram_addr), 32'(gfx_vaddr));
        cpu_req = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        last_rd = 16'h0;
        exp_stall = 0;
        repeat (3) @(negedge clk);
        cpu_access(1'b0, 14'h0123, 16'h0, 2'b00, 1'b0, lat);
        check("post_rst_latency", 32'(lat), 32'd2);
        check("post_rst_data", 32'(cpu_rddata), 32'hBEEF);

        // Randomized traffic against random graphics lines.
        fork
            begin
                repeat (25) begin
                    repeat ($urandom_range(0, 12)) @(negedge clk);
                    gfx_line(int'($urandom_range(1, 20)));
                end
            end
            begin
                repeat (120) begin
                    logic [13:0] a;
                    a = ($urandom_range(0, 7) == 0) ? 14'h0123 : 14'(14'h3FF0 + $urandom_range(0, 15));
                    cpu_access(1'($urandom_range(0, 1)), a, 16'($urandom),
                               2'($urandom_range(0, 3)), 1'b0, lat);
                end
            end
        join
        repeat (3) @(negedge clk);
        check("rand_stall_max", 32'(stall_max), 32'(exp_stall));
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
